fir_mac_sequencer: RTL and testbench

Hardware sequencer that computes a direct-form FIR filter, y[i] = sum over j of coeffs[j]*data[i-j], by time-sharing one Rocket-style MulDiv unit through its req/resp handshake. It sits between the data and coefficient memories and the shared multiplier in the power-evaluation system top. It replaces the software tap loop: it generates indices, issues one multiply per tap, applies the per-tap binary-point shift, accumulates, and streams one output sample per input sample.

---
 rtl/fir_mac_sequencer.sv | 145 ++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: direct-form FIR engine that time-shares one MulDiv unit,
// issuing one multiply per tap and streaming one accumulated sample per input.
module fir_mac_sequencer #(
  parameter int XLEN = 32,
  parameter int ADDR_W = 11,
  parameter int ORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   cfg_num_data,
  input  logic [ORD_W:0]    cfg_order,
  input  logic [1:0]        cfg_mode,
  input  logic [4:0]        cfg_binary_point,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] data_addr,
  input  logic [XLEN-1:0]   data_rdata,
  output logic [ORD_W-1:0]  coef_addr,
  input  logic [XLEN-1:0]   coef_rdata,
  output logic              mul_req_valid,
  input  logic              mul_req_ready,
  output logic [3:0]        mul_req_fn,
  output logic              mul_req_dw,
  output logic [4:0]        mul_req_tag,
  output logic [XLEN-1:0]   mul_rs1,
  output logic [XLEN-1:0]   mul_rs2,
  output logic              mul_kill,
  input  logic              mul_resp_valid,
  output logic              mul_resp_ready,
  input  logic [XLEN-1:0]   mul_resp_data,
  input  logic [4:0]        mul_resp_tag,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [XLEN-1:0]   y_data,
  output logic [ADDR_W-1:0] y_index
);
  localparam int OW = ORD_W + 1;
  localparam int NW = ADDR_W + 1;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, ACCUM, EMIT, FIN} state_t;
  state_t state;
  logic [ADDR_W:0] n_r;
  logic [ORD_W:0] m_r;
  logic fix_r;
  logic [4:0] bp_r;
  logic [ADDR_W-1:0] i;
  logic [ORD_W-1:0] j;
  logic [XLEN-1:0] acc, prod, p, acc_next;
  logic more, last;
  assign p = fix_r ? $unsigned($signed(prod) >>> bp_r) : prod;
  assign acc_next = acc + p;
  assign more = (ADDR_W'(j) < i) && (OW'(j) < m_r - OW'(1));
  assign last = {1'b0, i} == n_r - NW'(1);
  assign mul_req_fn = '0;
  assign mul_req_dw = 1'b0;
  assign mul_kill = 1'b0;
  assign mul_req_tag = j[4:0];
  // Memories answer one cycle after FETCH, so operands come straight from the
  // read ports; the addresses are held through ISSUE, which keeps them stable.
  assign mul_rs1 = mul_req_valid ? coef_rdata : '0;
  assign mul_rs2 = mul_req_valid ? data_rdata : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      {busy, done, mul_req_valid, mul_resp_ready, y_valid} <= '0;
      data_addr <= '0;
      coef_addr <= '0;
      y_data <= '0;
      y_index <= '0;
      n_r <= '0;
      m_r <= '0;
      fix_r <= 1'b0;
      bp_r <= '0;
      i <= '0;
      j <= '0;
      acc <= '0;
      prod <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          n_r <= cfg_num_data;
          m_r <= cfg_order;
          fix_r <= cfg_mode[1];
          bp_r <= cfg_binary_point;
          i <= '0;
          j <= '0;
          acc <= '0;
          busy <= 1'b1;
          data_addr <= '0;
          coef_addr <= '0;
          state <= (cfg_num_data == '0 || cfg_order == '0) ? FIN : FETCH;
        end
        FETCH: begin
          mul_req_valid <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: if (mul_req_ready) begin
          mul_req_valid <= 1'b0;
          mul_resp_ready <= 1'b1;
          state <= WAIT;
        end
        WAIT: if (mul_resp_valid && mul_resp_tag == j[4:0]) begin
          prod <= mul_resp_data;
          mul_resp_ready <= 1'b0;
          state <= ACCUM;
        end
        ACCUM: begin
          acc <= acc_next;
          if (more) begin
            j <= j + ORD_W'(1);
            data_addr <= data_addr - ADDR_W'(1);
            coef_addr <= coef_addr + ORD_W'(1);
            state <= FETCH;
          end else begin
            y_valid <= 1'b1;
            y_data <= acc_next;
            y_index <= i;
            state <= EMIT;
          end
        end
        EMIT: if (y_ready) begin
          y_valid <= 1'b0;
          if (last) begin
            busy <= 1'b0;
            done <= 1'b1;
            state <= FIN;
          end else begin
            i <= i + ADDR_W'(1);
            j <= '0;
            acc <= '0;
            data_addr <= i + ADDR_W'(1);
            coef_addr <= '0;
            state <= FETCH;
          end
        end
        // Arriving from EMIT done is already high; a degenerate run raises it here.
        FIN: begin
          busy <= 1'b0;
          done <= ~done;
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed FIR runs against memory and tagged multiplier models.
module tb_fir_mac_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [11:0] cfg_num_data = '0;
  logic [8:0] cfg_order = '0;
  logic [1:0] cfg_mode = '0;
  logic [4:0] cfg_binary_point = '0;
  logic busy, done, mul_req_valid, mul_req_dw, mul_kill, mul_resp_ready, y_valid;
  logic [10:0] data_addr, y_index;
  logic [7:0] coef_addr;
  logic [31:0] data_rdata = '0, coef_rdata = '0, mul_rs1, mul_rs2, y_data;
  logic [3:0] mul_req_fn;
  logic [4:0] mul_req_tag, mul_resp_tag = '0;
  logic mul_req_ready = 1'b1, mul_resp_valid = 1'b0, y_ready = 1'b1;
  logic [31:0] mul_resp_data = '0;
  logic [31:0] dmem [0:2047];
  logic [31:0] cmem [0:255];
  int lat = 1, nreq = 0, nbad = 0, done_cnt = 0, cnt = 0;
  logic inject = 1'b0, flush = 1'b0, pend = 1'b0, bad = 1'b0;
  logic [31:0] pdata = '0;
  logic [4:0] ptag = '0;
  logic [31:0] yq_d[$];
  logic [10:0] yq_i[$];
  logic [31:0] ex1 [0:3] = '{32'd1, 32'd3, 32'd5, 32'd7};
  int vectors = 0, miscompares = 0;

  fir_mac_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_num_data(cfg_num_data),
    .cfg_order(cfg_order), .cfg_mode(cfg_mode), .cfg_binary_point(cfg_binary_point),
    .busy(busy), .done(done), .data_addr(data_addr), .data_rdata(data_rdata),
    .coef_addr(coef_addr), .coef_rdata(coef_rdata), .mul_req_valid(mul_req_valid),
    .mul_req_ready(mul_req_ready), .mul_req_fn(mul_req_fn), .mul_req_dw(mul_req_dw),
    .mul_req_tag(mul_req_tag), .mul_rs1(mul_rs1), .mul_rs2(mul_rs2), .mul_kill(mul_kill),
    .mul_resp_valid(mul_resp_valid), .mul_resp_ready(mul_resp_ready),
    .mul_resp_data(mul_resp_data), .mul_resp_tag(mul_resp_tag), .y_valid(y_valid),
    .y_ready(y_ready), .y_data(y_data), .y_index(y_index)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories plus a single-outstanding multiplier that can
  // precede each real response with one carrying a corrupted tag.
  always @(posedge clk) begin
    data_rdata <= dmem[data_addr];
    coef_rdata <= cmem[coef_addr];
    if (flush) begin
      pend <= 1'b0;
      mul_resp_valid <= 1'b0;
    end else begin
      if (mul_req_valid && mul_req_ready && !pend) begin
        pend <= 1'b1;
        bad <= inject;
        pdata <= mul_rs1 * mul_rs2;
        ptag <= mul_req_tag;
        cnt <= lat;
        nreq <= nreq + 1;
      end
      if (mul_resp_valid && mul_resp_ready) mul_resp_valid <= 1'b0;
      else if (pend && !mul_resp_valid) begin
        if (cnt > 1) cnt <= cnt - 1;
        else if (bad) begin
          mul_resp_valid <= 1'b1;
          mul_resp_tag <= ptag ^ 5'h1F;
          mul_resp_data <= 32'h0BAD0BAD;
          bad <= 1'b0;
          cnt <= lat;
          nbad <= nbad + 1;
        end else begin
          mul_resp_valid <= 1'b1;
          mul_resp_tag <= ptag;
          mul_resp_data <= pdata;
          pend <= 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && y_valid && y_ready) begin
      yq_d.push_back(y_data);
      yq_i.push_back(y_index);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [31:0] yv(input int k);
    return (yq_d.size() > k) ? yq_d[k] : 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] yi(input int k);
    return (yq_i.size() > k) ? {21'b0, yq_i[k]} : 32'hDEADBEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic go(input int n, input int m, input int mode, input int bp);
    yq_d.delete();
    yq_i.delete();
    @(negedge clk);
    cfg_num_data = 12'(n);
    cfg_order = 9'(m);
    cfg_mode = 2'(mode);
    cfg_binary_point = 5'(bp);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 1000 && !done; k++) @(negedge clk);
    check(tag, {31'b0, done}, 32'd1);
    @(negedge clk);
  endtask

  task automatic check_t1(input string tag);
    check({tag, "_cnt"}, yq_d.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_y%0d", tag, k), yv(k), ex1[k]);
      check($sformatf("%s_idx%0d", tag, k), yi(k), k);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r1, r2, yd;
    logic ok;
    int q, d0;
    for (int k = 0; k < 2048; k++) dmem[k] = '0;
    for (int k = 0; k < 256; k++) cmem[k] = '0;
    @(negedge clk);
    check("rst_ctl", {27'b0, busy, done, mul_req_valid, mul_resp_ready, y_valid}, 32'd0);
    check("rst_data", {13'b0, data_addr, coef_addr} | y_data | mul_rs1 | mul_rs2, 32'd0);
    rst_n = 1'b1;
    // unsigned: data 1..4, coeffs 1,1
    dmem[0] = 1; dmem[1] = 2; dmem[2] = 3; dmem[3] = 4;
    cmem[0] = 1; cmem[1] = 1;
    lat = 3;
    q = nreq; d0 = done_cnt;
    check("t1_idle_busy", {31'b0, busy}, 32'd0);
    go(4, 2, 0, 0);
    check("t1_busy", {31'b0, busy}, 32'd1);
    wait_done("t1_done");
    check_t1("t1");
    check("t1_nreq", nreq - q, 32'd7);
    check("t1_ndone", done_cnt - d0, 32'd1);
    // signed, with an ignored start mid-run
    dmem[0] = -2; dmem[1] = 5; cmem[0] = 3; cmem[1] = -1;
    lat = 2; d0 = done_cnt;
    go(2, 2, 1, 0);
    repeat (3) @(negedge clk);
    cfg_num_data = 12'd1; cfg_order = 9'd0; cfg_mode = 2'd2; cfg_binary_point = 5'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t2_done");
    check("t2_cnt", yq_d.size(), 32'd2);
    check("t2_y0", yv(0), 32'hFFFFFFFA);
    check("t2_y1", yv(1), 32'd17);
    check("t2_ndone", done_cnt - d0, 32'd1);
    repeat (3) @(negedge clk);
    check("t2_idle", {31'b0, busy}, 32'd0);
    // fixed point: -24*32 = -768, >>>4 = -48
    dmem[0] = 32; cmem[0] = -24;
    go(1, 1, 2, 4);
    wait_done("t3_done");
    check("t3_y0", yv(0), 32'hFFFFFFD0);
    // handshake stress
    dmem[0] = 1; dmem[1] = 2; dmem[2] = 3; dmem[3] = 4;
    cmem[0] = 1; cmem[1] = 1;
    lat = 1; mul_req_ready = 1'b0; y_ready = 1'b0;
    go(4, 2, 0, 0);
    for (int k = 0; k < 20 && !mul_req_valid; k++) @(negedge clk);
    check("t4_reqv", {31'b0, mul_req_valid}, 32'd1);
    check("t4_consts", {23'b0, mul_req_fn, mul_req_dw, mul_kill, mul_req_tag}, 32'd0);
    r1 = mul_rs1; r2 = mul_rs2;
    check("t4_rs", {r1[15:0], r2[15:0]}, 32'h00010001);
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (!mul_req_valid || mul_rs1 !== r1 || mul_rs2 !== r2) ok = 1'b0;
    end
    check("t4_req_stable", {31'b0, ok}, 32'd1);
    mul_req_ready = 1'b1;
    for (int k = 0; k < 50 && !y_valid; k++) @(negedge clk);
    check("t4_yv", {31'b0, y_valid}, 32'd1);
    yd = y_data;
    check("t4_yd", yd, 32'd1);
    q = nreq; ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!y_valid || y_data !== yd || mul_req_valid) ok = 1'b0;
    end
    check("t4_y_stable", {31'b0, ok}, 32'd1);
    check("t4_noreq", nreq - q, 32'd0);
    y_ready = 1'b1;
    wait_done("t4_done");
    check_t1("t4");
    // wrong-tag responses precede every real one
    inject = 1'b1; lat = 2; q = nbad;
    go(4, 2, 0, 0);
    wait_done("t5_done");
    inject = 1'b0;
    check("t5_nbad", nbad - q, 32'd7);
    check_t1("t5");
    // reset while waiting on the first tap of sample 2
    lat = 6; d0 = done_cnt;
    go(4, 2, 0, 0);
    for (int k = 0; k < 200 && !(mul_resp_ready && data_addr == 11'd2); k++) @(negedge clk);
    check("t6_inwait", {31'b0, mul_resp_ready}, 32'd1);
    check("t6_ypre", y_data, 32'd3);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_ctl", {27'b0, busy, done, mul_req_valid, mul_resp_ready, y_valid}, 32'd0);
    check("t6_rst_data", {13'b0, data_addr, coef_addr} | y_data | {21'b0, y_index}, 32'd0);
    for (int k = 0; k < 10 && !mul_resp_valid; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("t6_stale", {30'b0, mul_resp_valid, mul_resp_ready}, 32'd2);
    check("t6_nodone", done_cnt - d0, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    rst_n = 1'b1;
    lat = 1;
    go(4, 2, 0, 0);
    wait_done("t6_done");
    check_t1("t6");
    // degenerate M=0
    q = nreq;
    go(5, 0, 0, 0);
    check("t7_c1", {30'b0, busy, done}, 32'd2);
    @(negedge clk);
    check("t7_c2", {30'b0, busy, done}, 32'd1);
    @(negedge clk);
    check("t7_nreq", nreq - q, 32'd0);
    check("t7_ny", yq_d.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
